// File: rtl/bus_pkg.sv
// Shared constants for the peripheral bus controller: slave indices, address-map
// pages, FSM state encoding and the fallback read data.
package bus_pkg;

    localparam int N_SLV_DEF = 7;

    // One-hot slave indices
    localparam int SLV_RAM     = 0;
    localparam int SLV_BIN2BCD = 1;
    localparam int SLV_DIV     = 2;
    localparam int SLV_MULT    = 3;
    localparam int SLV_GPIO    = 4;
    localparam int SLV_UART    = 5;
    localparam int SLV_SCREEN  = 6;

    // Address-map pages (cpu_addr[31:16]); anything else falls through to RAM
    localparam logic [15:0] PAGE_UART    = 16'h0040;
    localparam logic [15:0] PAGE_GPIO    = 16'h0041;
    localparam logic [15:0] PAGE_MULT    = 16'h0042;
    localparam logic [15:0] PAGE_DIV     = 16'h0043;
    localparam logic [15:0] PAGE_BIN2BCD = 16'h0044;
    localparam logic [15:0] PAGE_SCREEN  = 16'h0045;

    // FSM state encoding
    typedef logic [1:0] bus_state_t;
    localparam bus_state_t ST_IDLE   = 2'd0;
    localparam bus_state_t ST_ACCESS = 2'd1;
    localparam bus_state_t ST_WAIT   = 2'd2;
    localparam bus_state_t ST_DONE   = 2'd3;

    // Read data returned on timeout or on a select that maps to no slave
    localparam logic [31:0] BUS_DEFAULT_RDATA = 32'h6666_6666;

    function automatic logic [15:0] addr_page(input logic [31:0] addr);
        return addr[31:16];
    endfunction

endpackage

// File: rtl/periph_bus_ctrl_if.sv
// Bundle of CPU-side and peripheral-side signals of the bus controller.
//
// Handshake: the CPU raises cpu_rstrb (read) or a nonzero cpu_wmask (write) for
// one cycle while the controller is idle. The controller answers with
// cpu_rbusy/cpu_wbusy high from the next cycle until the access completes; the
// cycle busy drops is the completion cycle, and for reads cpu_rdata is valid
// from then on. Towards the peripherals, per_cs stays selected for the whole
// access, per_rd/per_wr pulse for exactly one cycle, and the selected slave
// answers by raising its per_ready bit together with its per_rdata word.
//
// Modport master: the controller (it masters the peripheral bus).
// Modport slave : the environment (CPU plus peripherals).
interface periph_bus_ctrl_if #(
    parameter int N_SLV = 7
);
    logic [31:0]        cpu_addr;
    logic               cpu_rstrb;
    logic [3:0]         cpu_wmask;
    logic [31:0]        cpu_rdata;
    logic               cpu_rbusy;
    logic               cpu_wbusy;
    logic [N_SLV-1:0]   per_cs;
    logic               per_rd;
    logic               per_wr;
    logic [31:0]        per_addr;
    logic [32*N_SLV-1:0] per_rdata;
    logic [N_SLV-1:0]   per_ready;
    logic [31:0]        err_addr;
    logic               err_irq;
    logic               err_clr;

    modport master (
        input  cpu_addr, cpu_rstrb, cpu_wmask, per_rdata, per_ready, err_clr,
        output cpu_rdata, cpu_rbusy, cpu_wbusy, per_cs, per_rd, per_wr,
               per_addr, err_addr, err_irq
    );

    modport slave (
        output cpu_addr, cpu_rstrb, cpu_wmask, per_rdata, per_ready, err_clr,
        input  cpu_rdata, cpu_rbusy, cpu_wbusy, per_cs, per_rd, per_wr,
               per_addr, err_addr, err_irq
    );
endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: cpu_addr[31:16] page to one-hot slave select.
// Pages whose slave index does not fit in N_SLV yield an all-zero select.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int N_SLV = N_SLV_DEF
) (
    input  logic [15:0]      page_i,
    output logic [N_SLV-1:0] cs_o
);

    logic [2:0] idx;

    // Map the page to a slave index, then expand to one-hot
    always_comb begin
        idx  = 3'(SLV_RAM);
        cs_o = '0;
        case (page_i)
            PAGE_UART:    idx = 3'(SLV_UART);
            PAGE_GPIO:    idx = 3'(SLV_GPIO);
            PAGE_MULT:    idx = 3'(SLV_MULT);
            PAGE_DIV:     idx = 3'(SLV_DIV);
            PAGE_BIN2BCD: idx = 3'(SLV_BIN2BCD);
            PAGE_SCREEN:  idx = 3'(SLV_SCREEN);
            default:      idx = 3'(SLV_RAM);
        endcase
        for (int i = 0; i < N_SLV; i++) begin
            cs_o[i] = (int'(idx) == i);
        end
    end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: sequences CPU loads/stores onto the SoC peripheral
// bus (decode, one-cycle strobe, ready wait with timeout, read-data return).
// Optional feature macro: BUS_ERR_LOG_EN enables the timeout error log
// (err_addr / sticky err_irq with err_clr).
module periph_bus_ctrl
    import bus_pkg::*;
#(
    parameter int          N_SLV         = N_SLV_DEF,
    parameter int          TIMEOUT       = 255,
    parameter logic [31:0] DEFAULT_RDATA = BUS_DEFAULT_RDATA
) (
    input  logic                 clk,
    input  logic                 resetn,
    periph_bus_ctrl_if.master    bus,
    output logic [1:0]           dbg_state_o
);

    bus_state_t       state_q, state_d;
    logic [N_SLV-1:0] cs_q, cs_d, dec_cs;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_q, wr_d;
    logic [15:0]      cnt_q, cnt_d, cnt_inc;
    logic             req;
    logic             sel_ready;
    logic             timeout_hit;
    logic [31:0]      sel_rdata;

    bus_addr_decode #(.N_SLV(N_SLV)) u_decode (
        .page_i (addr_page(bus.cpu_addr)),
        .cs_o   (dec_cs)
    );

    // A nonzero write mask makes the access a write even if rstrb is also set
    assign req         = bus.cpu_rstrb | (|bus.cpu_wmask);
    assign sel_ready   = |(bus.per_ready & cs_q);
    assign timeout_hit = (cnt_q >= 16'(TIMEOUT));
    assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // Read-data mux over the latched one-hot select
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (cs_q[i]) sel_rdata = sel_rdata | bus.per_rdata[32*i +: 32];
        end
    end

    // Access sequencer: IDLE -> ACCESS -> (WAIT) -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACCESS;
                    cs_d    = dec_cs;
                    addr_d  = bus.cpu_addr;
                    wr_d    = |bus.cpu_wmask;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_inc;
                if (cs_q[SLV_RAM] || (cs_q == '0)) begin
                    // RAM answers in a fixed cycle; an empty select has no one to wait for
                    state_d = ST_DONE;
                    if (!wr_q) rdata_d = cs_q[SLV_RAM] ? sel_rdata : DEFAULT_RDATA;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (sel_ready) begin
                    state_d = ST_DONE;
                    if (!wr_q) rdata_d = sel_rdata;
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    if (!wr_q) rdata_d = DEFAULT_RDATA;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cs_d    = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cs_q    <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_rbusy = ((state_q == ST_ACCESS) || (state_q == ST_WAIT)) && !wr_q;
    assign bus.cpu_wbusy = ((state_q == ST_ACCESS) || (state_q == ST_WAIT)) &&  wr_q;
    assign bus.per_cs    = cs_q;
    assign bus.per_rd    = (state_q == ST_ACCESS) && !wr_q;
    assign bus.per_wr    = (state_q == ST_ACCESS) &&  wr_q;
    assign bus.per_addr  = addr_q;
    assign dbg_state_o   = state_q;

`ifdef BUS_ERR_LOG_EN
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_irq_q, err_irq_d;
    logic        timeout_evt;

    // A ready arriving on the timeout cycle is a normal completion, not an error
    assign timeout_evt = (state_q == ST_WAIT) && !sel_ready && timeout_hit;

    // Error log: a new timeout outranks a simultaneous clear
    always_comb begin
        err_addr_d = err_addr_q;
        err_irq_d  = err_irq_q;
        if (timeout_evt) begin
            err_addr_d = addr_q;
            err_irq_d  = 1'b1;
        end else if (bus.err_clr) begin
            err_irq_d  = 1'b0;
        end
    end

    // Error log registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_addr_q <= '0;
            err_irq_q  <= 1'b0;
        end else begin
            err_addr_q <= err_addr_d;
            err_irq_q  <= err_irq_d;
        end
    end

    assign bus.err_addr = err_addr_q;
    assign bus.err_irq  = err_irq_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = bus.err_clr;
    assign bus.err_addr   = '0;
    assign bus.err_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Testbench for periph_bus_ctrl: directed accesses, scoreboard with expected
// queue, monitor that checks every completed access.
module tb_periph_bus_ctrl;
    import bus_pkg::*;

    localparam int N = 7;
    localparam int NEVER = 16'hFFFF;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [7:0]  busy;
        logic        wr;
        logic [N-1:0] cs;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] dbg_state;
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    int         lat_tb = NEVER;
    logic [N-1:0] ready_tb = '0;
    exp_t       exp_q[$];

    periph_bus_ctrl_if #(.N_SLV(N)) bus ();

    periph_bus_ctrl #(.N_SLV(N), .TIMEOUT(10)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    assign bus.per_ready = ready_tb;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // peripheral model: ready for the selected slave lat_tb cycles into WAIT
    int   pc = 0;
    logic active = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            pc = 0;
            active = 1'b0;
            ready_tb = '0;
        end else begin
            if (bus.per_rd || bus.per_wr) begin
                active = 1'b1;
                pc = 0;
            end else if (active) begin
                pc++;
            end
            if (!(bus.cpu_rbusy || bus.cpu_wbusy)) active = 1'b0;
            ready_tb = (active && pc == lat_tb) ? bus.per_cs : '0;
        end
    end

    // monitor: on every completion (busy falling) pop and compare
    int   rb_cnt = 0, wb_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    logic [N-1:0] cs_seen = '0;
    logic [31:0]  addr_seen = '0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!resetn) begin
            rb_cnt = 0; wb_cnt = 0; rd_cnt = 0; wr_cnt = 0;
            prev_busy = 1'b0;
        end else begin
            if (bus.cpu_rbusy) rb_cnt++;
            if (bus.cpu_wbusy) wb_cnt++;
            if (bus.per_rd) rd_cnt++;
            if (bus.per_wr) wr_cnt++;
            if (bus.per_rd || bus.per_wr) begin
                cs_seen = bus.per_cs;
                addr_seen = bus.per_addr;
            end
            if (prev_busy && !(bus.cpu_rbusy || bus.cpu_wbusy)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", bus.cpu_rdata, e.rdata);
                    check("busy_cycles", e.wr ? wb_cnt : rb_cnt, 32'(e.busy));
                    check("other_busy", e.wr ? rb_cnt : wb_cnt, 32'd0);
                    check("strobe_pulses", e.wr ? wr_cnt : rd_cnt, 32'd1);
                    check("wrong_strobe", e.wr ? rd_cnt : wr_cnt, 32'd0);
                    check("per_cs", 32'(cs_seen), 32'(e.cs));
                    check("per_addr", addr_seen, e.addr);
                    check("done_state", 32'(dbg_state), 32'(ST_DONE));
                end
                done_cnt++;
                rb_cnt = 0; wb_cnt = 0; rd_cnt = 0; wr_cnt = 0;
            end
            prev_busy = bus.cpu_rbusy || bus.cpu_wbusy;
        end
    end

    task automatic wait_done();
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == start) begin
            check("completion_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    // driver: one CPU access with its expected response pushed first
    task automatic do_access(input logic [31:0] addr, input logic rstrb,
                             input logic [3:0] wmask, input int slot,
                             input logic [31:0] data, input int latency,
                             input logic [31:0] exp_rdata, input int exp_busy,
                             input logic exp_wr, input logic [N-1:0] exp_cs);
        exp_t e;
        bus.per_rdata[32*slot +: 32] = data;
        lat_tb = latency;
        e.rdata = exp_rdata;
        e.addr = addr;
        e.busy = 8'(exp_busy);
        e.wr = exp_wr;
        e.cs = exp_cs;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.cpu_addr = addr;
        bus.cpu_rstrb = rstrb;
        bus.cpu_wmask = wmask;
        @(posedge clk); #1;
        bus.cpu_rstrb = 1'b0;
        bus.cpu_wmask = 4'h0;
        wait_done();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdata"}, bus.cpu_rdata, 32'h0);
        check({tag, "_rbusy"}, 32'(bus.cpu_rbusy), 32'd0);
        check({tag, "_wbusy"}, 32'(bus.cpu_wbusy), 32'd0);
        check({tag, "_per_cs"}, 32'(bus.per_cs), 32'd0);
        check({tag, "_per_rd"}, 32'(bus.per_rd), 32'd0);
        check({tag, "_per_wr"}, 32'(bus.per_wr), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check({tag, "_err_irq"}, 32'(bus.err_irq), 32'd0);
        check({tag, "_err_addr"}, bus.err_addr, 32'h0);
    endtask

    task automatic err_clr_pulse();
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_rstrb = 1'b0;
        bus.cpu_wmask = 4'h0;
        bus.err_clr = 1'b0;
        for (int i = 0; i < N; i++) bus.per_rdata[32*i +: 32] = 32'h1000_0000 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        check_reset("init");
        resetn = 1'b1;

        // RAM read: one stall cycle
        do_access(32'h0000_0100, 1'b1, 4'h0, SLV_RAM, 32'hDEAD_BEEF, NEVER,
                  32'hDEAD_BEEF, 1, 1'b0, 7'b0000001);
        // mult read, ready after 5 WAIT cycles
        do_access(32'h0042_0004, 1'b1, 4'h0, SLV_MULT, 32'h0000_0051, 5,
                  32'h0000_0051, 6, 1'b0, 7'b0001000);
        // uart write, rdata holds
        do_access(32'h0040_0010, 1'b0, 4'b0001, SLV_UART, 32'h5555_5555, 2,
                  32'h0000_0051, 3, 1'b1, 7'b0100000);
        // gpio read
        do_access(32'h0041_0000, 1'b1, 4'h0, SLV_GPIO, 32'hA5A5_0001, 3,
                  32'hA5A5_0001, 4, 1'b0, 7'b0010000);
        // ready on the very timeout cycle: ready wins, no error logged
        do_access(32'h0043_0008, 1'b1, 4'h0, SLV_DIV, 32'hCAFE_0010, 10,
                  32'hCAFE_0010, 11, 1'b0, 7'b0000100);
        #1;
        check("ready_wins_err_irq", 32'(bus.err_irq), 32'd0);
        check("ready_wins_err_addr", bus.err_addr, 32'h0);

        // div read that never gets ready: timeout
        do_access(32'h0043_0000, 1'b1, 4'h0, SLV_DIV, 32'h7777_7777, NEVER,
                  32'h6666_6666, 11, 1'b0, 7'b0000100);
        #1;
`ifdef BUS_ERR_LOG_EN
        check("timeout_err_irq", 32'(bus.err_irq), 32'd1);
        check("timeout_err_addr", bus.err_addr, 32'h0043_0000);
`else
        check("timeout_err_irq", 32'(bus.err_irq), 32'd0);
        check("timeout_err_addr", bus.err_addr, 32'h0);
`endif

        // reset in the middle of WAIT
        lat_tb = NEVER;
        @(posedge clk); #1;
        bus.cpu_addr = 32'h0043_0004;
        bus.cpu_rstrb = 1'b1;
        @(posedge clk); #1;
        bus.cpu_rstrb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_wait_rbusy", 32'(bus.cpu_rbusy), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check_reset("midreset");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // normal RAM read after the aborted access
        do_access(32'h0000_0200, 1'b1, 4'h0, SLV_RAM, 32'h1234_5678, NEVER,
                  32'h1234_5678, 1, 1'b0, 7'b0000001);
        // rstrb and wmask together: write wins
        do_access(32'h0044_0000, 1'b1, 4'hF, SLV_BIN2BCD, 32'h9999_9999, 1,
                  32'h1234_5678, 2, 1'b1, 7'b0000010);
        // unmapped page falls through to RAM
        do_access(32'h0046_0000, 1'b1, 4'h0, SLV_RAM, 32'h0BAD_F00D, NEVER,
                  32'h0BAD_F00D, 1, 1'b0, 7'b0000001);
        // screen read timeout, then clear the error flag
        do_access(32'h0045_0000, 1'b1, 4'h0, SLV_SCREEN, 32'h3333_3333, NEVER,
                  32'h6666_6666, 11, 1'b0, 7'b1000000);
        #1;
`ifdef BUS_ERR_LOG_EN
        check("screen_err_irq", 32'(bus.err_irq), 32'd1);
        check("screen_err_addr", bus.err_addr, 32'h0045_0000);
        err_clr_pulse();
        check("err_clr_irq", 32'(bus.err_irq), 32'd0);
        check("err_clr_addr_held", bus.err_addr, 32'h0045_0000);
`else
        check("screen_err_irq", 32'(bus.err_irq), 32'd0);
        check("screen_err_addr", bus.err_addr, 32'h0);
        err_clr_pulse();
        check("err_clr_irq", 32'(bus.err_irq), 32'd0);
        check("err_clr_addr_held", bus.err_addr, 32'h0);
`endif
        // screen write, rdata keeps the timeout value
        do_access(32'h0045_0008, 1'b0, 4'b1100, SLV_SCREEN, 32'h4444_4444, 1,
                  32'h6666_6666, 2, 1'b1, 7'b1000000);

        repeat (2) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
